// File: rtl/axi_llc_tag_bist_check_if.sv
// Tag-SRAM BIST checker bus: generator/SRAM-side request and read data in, compare results and stats out.
// The master modport is the pattern-generator side; the slave modport is the checker.
interface axi_llc_tag_bist_check_if #(
   parameter int unsigned SetAssociativity = 1,
   parameter int unsigned IndexLength      = 1,
   parameter int unsigned PatternWidth     = 1,
   parameter int unsigned CntWidth         = 16
);
   logic                                     req_i;
   logic                                     we_i;
   logic [IndexLength-1:0]                   index_i;
   logic [PatternWidth-1:0]                  pattern_i;
   logic [SetAssociativity*PatternWidth-1:0] rdata_i;
   logic                                     clear_i;
   logic [SetAssociativity-1:0]              bist_res_o;
   logic                                     bist_res_valid_o;
   logic [CntWidth-1:0]                      err_cnt_o;
   logic                                     first_fail_valid_o;
   logic [IndexLength-1:0]                   first_fail_index_o;
   logic [SetAssociativity-1:0]              first_fail_way_o;

   modport master (
      output req_i, we_i, index_i, pattern_i, rdata_i, clear_i,
      input  bist_res_o, bist_res_valid_o, err_cnt_o,
             first_fail_valid_o, first_fail_index_o, first_fail_way_o
   );

   modport slave (
      input  req_i, we_i, index_i, pattern_i, rdata_i, clear_i,
      output bist_res_o, bist_res_valid_o, err_cnt_o,
             first_fail_valid_o, first_fail_index_o, first_fail_way_o
   );
endinterface

// File: rtl/axi_llc_tag_bist_check.sv
// Tag-SRAM march-BIST read checker: result ReadLatency+1 cycles after each read, one read per cycle.
// No backpressure; expected patterns ride a ReadLatency-deep pipeline alongside the SRAM access.
module axi_llc_tag_bist_check #(
   parameter int unsigned SetAssociativity = 1,
   parameter int unsigned IndexLength      = 1,
   parameter int unsigned PatternWidth     = 1,
   parameter int unsigned ReadLatency      = 1,
   parameter int unsigned CntWidth         = 16
) (
   input logic                     clk_i,
   input logic                     rst_i,
   axi_llc_tag_bist_check_if.slave bus
);

   generate
      if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_latency
         $error("axi_llc_tag_bist_check: ReadLatency must be in 1..4");
      end
   endgenerate

   logic [ReadLatency-1:0]                   vld_q, vld_d;
   logic [ReadLatency-1:0][IndexLength-1:0]  idx_q, idx_d;
   logic [ReadLatency-1:0][PatternWidth-1:0] pat_q, pat_d;

   logic [SetAssociativity-1:0] res_q, res_d;
   logic                        res_vld_q, res_vld_d;
   logic [CntWidth-1:0]         cnt_q, cnt_d;
   logic                        ffv_q, ffv_d;
   logic [IndexLength-1:0]      ffi_q, ffi_d;
   logic [SetAssociativity-1:0] ffw_q, ffw_d;

   logic [SetAssociativity-1:0] match;
   logic                        last_vld;
   logic                        fail;

   always_comb begin
      vld_d    = vld_q;
      idx_d    = idx_q;
      pat_d    = pat_q;
      vld_d[0] = bus.req_i & ~bus.we_i;
      idx_d[0] = bus.index_i;
      pat_d[0] = bus.pattern_i;
      for (int s = 1; s < int'(ReadLatency); s++) begin
         vld_d[s] = vld_q[s-1];
         idx_d[s] = idx_q[s-1];
         pat_d[s] = pat_q[s-1];
      end

      // The last stage lines up with the data the SRAM returns this cycle.
      match = '0;
      for (int w = 0; w < int'(SetAssociativity); w++) begin
         match[w] = (bus.rdata_i[w*PatternWidth +: PatternWidth] == pat_q[ReadLatency-1]);
      end
      last_vld = vld_q[ReadLatency-1];
      fail     = last_vld & ~(&match);

      res_d     = last_vld ? match : res_q;
      res_vld_d = last_vld;

      cnt_d = cnt_q;
      ffv_d = ffv_q;
      ffi_d = ffi_q;
      ffw_d = ffw_q;
      // Clear wins over a same-cycle fail; the fail still shows on the result strobe.
      if (bus.clear_i) begin
         cnt_d = '0;
         ffv_d = 1'b0;
         ffi_d = '0;
         ffw_d = '0;
      end else if (fail) begin
         if (cnt_q != {CntWidth{1'b1}}) begin
            cnt_d = cnt_q + CntWidth'(1);
         end
         if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q[ReadLatency-1];
            ffw_d = ~match;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q     <= '0;
         idx_q     <= '0;
         pat_q     <= '0;
         res_q     <= '1;
         res_vld_q <= 1'b0;
         cnt_q     <= '0;
         ffv_q     <= 1'b0;
         ffi_q     <= '0;
         ffw_q     <= '0;
      end else begin
         vld_q     <= vld_d;
         idx_q     <= idx_d;
         pat_q     <= pat_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
         cnt_q     <= cnt_d;
         ffv_q     <= ffv_d;
         ffi_q     <= ffi_d;
         ffw_q     <= ffw_d;
      end
   end

   assign bus.bist_res_o         = res_q;
   assign bus.bist_res_valid_o   = res_vld_q;
   assign bus.err_cnt_o          = cnt_q;
   assign bus.first_fail_valid_o = ffv_q;
   assign bus.first_fail_index_o = ffi_q;
   assign bus.first_fail_way_o   = ffw_q;

endmodule

// File: tb/tb_axi_llc_tag_bist_check.sv
// Bench for axi_llc_tag_bist_check: one stimulus stream drives a ReadLatency=1 and a ReadLatency=3
// instance in parallel; each has its own SRAM read-data delay line and expected-result scoreboard.
module tb_axi_llc_tag_bist_check;
   localparam int NW  = 4;
   localparam int PW  = 8;
   localparam int IL  = 4;
   localparam int CW  = 4;
   localparam int RLA = 1;
   localparam int RLB = 3;

   typedef struct {
      int            due;
      logic [NW-1:0] res;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, req, we, clr;
   logic [IL-1:0]    idx;
   logic [PW-1:0]    pat;
   logic [NW*PW-1:0] rd_a, rd_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int nv_a   = 0;
   int nv_b   = 0;

   exp_t             q_a[$], q_b[$];
   logic [NW*PW-1:0] line_a[int], line_b[int];

   always @(posedge clk) cyc <= cyc + 1;

   axi_llc_tag_bist_check_if #(.SetAssociativity(NW), .IndexLength(IL), .PatternWidth(PW), .CntWidth(CW)) ia ();
   axi_llc_tag_bist_check_if #(.SetAssociativity(NW), .IndexLength(IL), .PatternWidth(PW), .CntWidth(CW)) ib ();

   assign ia.req_i = req;  assign ib.req_i = req;
   assign ia.we_i = we;    assign ib.we_i = we;
   assign ia.index_i = idx;   assign ib.index_i = idx;
   assign ia.pattern_i = pat; assign ib.pattern_i = pat;
   assign ia.clear_i = clr;   assign ib.clear_i = clr;
   assign ia.rdata_i = rd_a;
   assign ib.rdata_i = rd_b;

   axi_llc_tag_bist_check #(.SetAssociativity(NW), .IndexLength(IL), .PatternWidth(PW),
                            .ReadLatency(RLA), .CntWidth(CW)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ia));
   axi_llc_tag_bist_check #(.SetAssociativity(NW), .IndexLength(IL), .PatternWidth(PW),
                            .ReadLatency(RLB), .CntWidth(CW)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ib));

   function automatic logic [12:0] stats_a();
      return {ia.err_cnt_o, ia.first_fail_valid_o, ia.first_fail_index_o, ia.first_fail_way_o};
   endfunction

   function automatic logic [12:0] stats_b();
      return {ib.err_cnt_o, ib.first_fail_valid_o, ib.first_fail_index_o, ib.first_fail_way_o};
   endfunction

   function automatic logic [18:0] outs(input int d);
      if (d == 0) return {ia.bist_res_o, ia.bist_res_valid_o, stats_a()};
      return {ib.bist_res_o, ib.bist_res_valid_o, stats_b()};
   endfunction

   // SRAM read-data model: each read's data appears ReadLatency cycles after issue.
   initial begin
      rd_a = '0;
      rd_b = '0;
      forever begin
         @(posedge clk); #1;
         rd_a = line_a.exists(cyc) ? line_a[cyc] : '0;
         rd_b = line_b.exists(cyc) ? line_b[cyc] : '0;
         if (line_a.exists(cyc)) line_a.delete(cyc);
         if (line_b.exists(cyc)) line_b.delete(cyc);
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ia.bist_res_valid_o === 1'b1) begin
            nv_a++;
            checks++;
            if (q_a.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid_a cyc=%0d got valid=1 want 0", cyc);
            end else begin
               e = q_a.pop_front();
               if (e.due !== cyc || ia.bist_res_o !== e.res) begin
                  errors++;
                  $display("FAIL result_a got cyc=%0d res=%b want cyc=%0d res=%b", cyc, ia.bist_res_o, e.due, e.res);
               end
            end
         end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
            checks++;
            errors++;
            e = q_a.pop_front();
            $display("FAIL missing_valid_a cyc=%0d got valid=%b want 1 res=%b", cyc, ia.bist_res_valid_o, e.res);
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ib.bist_res_valid_o === 1'b1) begin
            nv_b++;
            checks++;
            if (q_b.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid_b cyc=%0d got valid=1 want 0", cyc);
            end else begin
               e = q_b.pop_front();
               if (e.due !== cyc || ib.bist_res_o !== e.res) begin
                  errors++;
                  $display("FAIL result_b got cyc=%0d res=%b want cyc=%0d res=%b", cyc, ib.bist_res_o, e.due, e.res);
               end
            end
         end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
            checks++;
            errors++;
            e = q_b.pop_front();
            $display("FAIL missing_valid_b cyc=%0d got valid=%b want 1 res=%b", cyc, ib.bist_res_valid_o, e.res);
         end
      end
   end

   task automatic drive(input logic r, input logic w, input logic c, input logic [IL-1:0] ix,
                        input logic [PW-1:0] p, input logic [NW*PW-1:0] dat);
      exp_t          e;
      logic [NW-1:0] m;
      @(posedge clk); #1;
      req = r; we = w; clr = c; idx = ix; pat = p;
      if (r && !w) begin
         for (int k = 0; k < NW; k++) m[k] = (dat[k*PW +: PW] == p);
         e.res = m;
         e.due = cyc + RLA + 1;
         q_a.push_back(e);
         e.due = cyc + RLB + 1;
         q_b.push_back(e);
         line_a[cyc + RLA] = dat;
         line_b[cyc + RLB] = dat;
      end
   endtask

   task automatic drain();
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout got pending a=%0d b=%0d want 0", q_a.size(), q_b.size());
         q_a.delete();
         q_b.delete();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; we = 1'b0; clr = 1'b0; idx = '0; pat = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (outs(d) !== {4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_values dut=%0d got %h want %h", d, outs(d), {4'hF, 1'b0, 13'h0});
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_all_zero();
      int a0, b0;
      a0 = nv_a; b0 = nv_b;
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 4'(i), 8'h00, '0);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 4'(i), 8'h00, '0);
      drain();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (((d == 0) ? stats_a() : stats_b()) !== 13'h0 || ((d == 0) ? nv_a - a0 : nv_b - b0) != 8) begin
            errors++;
            $display("FAIL all_zero dut=%0d got stats=%h valids=%0d want stats=0 valids=8",
                     d, (d == 0) ? stats_a() : stats_b(), (d == 0) ? nv_a - a0 : nv_b - b0);
         end
      end
   endtask

   task automatic test_fail_capture();
      drive(1'b1, 1'b0, 1'b0, 4'd5, 8'hFF, {8'hFF, 8'hFB, 8'hFF, 8'hFF});
      drain();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (((d == 0) ? stats_a() : stats_b()) !== {4'd1, 1'b1, 4'd5, 4'b0100}) begin
            errors++;
            $display("FAIL first_fail dut=%0d got %h want %h", d, (d == 0) ? stats_a() : stats_b(),
                     {4'd1, 1'b1, 4'd5, 4'b0100});
         end
      end
   endtask

   task automatic test_second_fail();
      drive(1'b1, 1'b0, 1'b0, 4'd3, 8'hFF, {8'hFF, 8'hFF, 8'hFF, 8'hFE});
      drain();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (((d == 0) ? stats_a() : stats_b()) !== {4'd2, 1'b1, 4'd5, 4'b0100}) begin
            errors++;
            $display("FAIL second_fail dut=%0d got %h want %h", d, (d == 0) ? stats_a() : stats_b(),
                     {4'd2, 1'b1, 4'd5, 4'b0100});
         end
      end
   endtask

   task automatic test_mixed();
      int a0, b0;
      a0 = nv_a; b0 = nv_b;
      drive(1'b1, 1'b1, 1'b0, 4'd1, 8'hA5, '0);
      drive(1'b1, 1'b0, 1'b0, 4'd2, 8'hA5, {4{8'hA5}});
      drive(1'b1, 1'b0, 1'b0, 4'd3, 8'hA5, {4{8'hA5}});
      drive(1'b1, 1'b1, 1'b0, 4'd4, 8'hA5, '0);
      drive(1'b1, 1'b0, 1'b0, 4'd5, 8'hA5, {4{8'hA5}});
      drain();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (((d == 0) ? nv_a - a0 : nv_b - b0) != 3) begin
            errors++;
            $display("FAIL mixed_valid_count dut=%0d got %0d want 3", d, (d == 0) ? nv_a - a0 : nv_b - b0);
         end
      end
   endtask

   task automatic test_saturate_clear();
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 4'(i), 8'h00, {4{8'h01}});
      drain();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (((d == 0) ? stats_a() : stats_b()) !== {4'hF, 1'b1, 4'd5, 4'b0100}) begin
            errors++;
            $display("FAIL saturate dut=%0d got %h want %h", d, (d == 0) ? stats_a() : stats_b(),
                     {4'hF, 1'b1, 4'd5, 4'b0100});
         end
      end
      // Clear held over the result cycle of both latencies.
      drive(1'b1, 1'b0, 1'b0, 4'd7, 8'h00, {4{8'h01}});
      repeat (3) drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
      drain();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (((d == 0) ? stats_a() : stats_b()) !== 13'h0) begin
            errors++;
            $display("FAIL clear_priority dut=%0d got %h want 0", d, (d == 0) ? stats_a() : stats_b());
         end
      end
   endtask

   task automatic test_reset_midflight();
      int a0, b0;
      drive(1'b1, 1'b0, 1'b0, 4'd9, 8'h00, {4{8'h01}});
      drain();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (((d == 0) ? stats_a() : stats_b()) !== {4'd1, 1'b1, 4'd9, 4'b1111}) begin
            errors++;
            $display("FAIL pre_reset_fail dut=%0d got %h want %h", d, (d == 0) ? stats_a() : stats_b(),
                     {4'd1, 1'b1, 4'd9, 4'b1111});
         end
      end
      a0 = nv_a; b0 = nv_b;
      drive(1'b1, 1'b0, 1'b0, 4'd2, 8'h00, {4{8'h01}});
      @(posedge clk); #1;
      rst = 1'b1; req = 1'b1; we = 1'b0; idx = 4'd3; pat = 8'h00;
      q_a.delete();
      q_b.delete();
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;
      repeat (6) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (outs(d) !== {4'hF, 1'b0, 13'h0} || ((d == 0) ? nv_a - a0 : nv_b - b0) != 0) begin
            errors++;
            $display("FAIL reset_midflight dut=%0d got outs=%h valids=%0d want outs=%h valids=0",
                     d, outs(d), (d == 0) ? nv_a - a0 : nv_b - b0, {4'hF, 1'b0, 13'h0});
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_all_zero();
      test_fail_capture();
      test_second_fail();
      test_mixed();
      test_saturate_clear();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_llc_tag_bist_check.md
# axi_llc_tag_bist_check

Read-response checker for the LLC tag-SRAM march BIST. It sits between the tag SRAM read port and the BIST pattern generator. It tracks every read request the generator issues and delays the expected pattern by the SRAM read latency. It then compares the returned data of each way against that pattern and reports a per-way pass vector with a valid strobe. It also keeps sticky statistics (error count, first failing index and ways) for debug and SPM configuration.

## Interface
- `SetAssociativity`, default 1: number of ways; width of all way vectors.
- `IndexLength`, default 1: width of the tag SRAM index.
- `PatternWidth`, default 1: bits per way entry (valid + dirty + tag).
- `ReadLatency`, default 1: SRAM read latency in cycles; legal range 1..4, elaboration error otherwise.
- `CntWidth`, default 16: width of the saturating error counter.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  1  SRAM request issued by the pattern generator this cycle.
- `we_i`  in  1  write enable accompanying `req_i`.
- `index_i`  in  IndexLength  SRAM index of the request.
- `pattern_i`  in  PatternWidth  pattern written, or expected on read.
- `rdata_i`  in  SetAssociativity*PatternWidth  SRAM read data; way w occupies bits [w*PatternWidth +: PatternWidth].
- `clear_i`  in  1  clear statistics.
- `bist_res_o`  out  SetAssociativity  per-way compare result; bit w = 1 means way w matched.
- `bist_res_valid_o`  out  1  `bist_res_o` valid, one cycle per checked read.
- `err_cnt_o`  out  CntWidth  number of failing reads since reset or clear, saturating.
- `first_fail_valid_o`  out  1  a failing read has been captured.
- `first_fail_index_o`  out  IndexLength  index of the first failing read.
- `first_fail_way_o`  out  SetAssociativity  failing-way vector of the first failing read (1 = failed).

## Operation
- Only reads (`req_i & ~we_i`) are tracked. Writes and idle cycles produce no response.
- Tracking pipeline: `ReadLatency` stages. Each stage holds {valid, index, expected pattern}. Stage 0 is loaded from the inputs every cycle, so one read per cycle is sustained with no backpressure.
- At stage `ReadLatency`, `rdata_i` belongs to that entry. Per way: match[w] = (rdata slice w == expected). The comparison is full-width and exact.
- Output register: if the last stage is valid, `bist_res_o` <= match and `bist_res_valid_o` <= 1. Otherwise `bist_res_valid_o` <= 0, and `bist_res_o` holds its last value.
- Fail means the last stage is valid and ~&match.
- Statistics update in the same cycle as the output register:
  - on fail, `err_cnt_o` increments by 1 and saturates at all-ones, with no wrap;
  - on the first fail while `first_fail_valid_o` = 0, index and ~match are captured and `first_fail_valid_o` is set; later fails leave the capture unchanged.
- `clear_i` zeroes `err_cnt_o`, `first_fail_valid_o`, `first_fail_index_o` and `first_fail_way_o`. Clear has priority: a fail in the same cycle is not counted or captured, but is still reported on `bist_res_o` and `bist_res_valid_o`.
- `clear_i` does not flush the tracking pipeline.
- `rst_i` mid-operation: all pipeline valids are cleared. No response is produced for reads in flight. Statistics are cleared.

## Timing
- Reset values: `bist_res_o` = '1, `bist_res_valid_o` = 0, `err_cnt_o` = 0, `first_fail_valid_o` = 0, `first_fail_index_o` = 0, `first_fail_way_o` = 0.
- A read issued in cycle t gives `bist_res_valid_o` high in cycle t+ReadLatency+1, for exactly one cycle.
- Statistics become visible in that same cycle t+ReadLatency+1.
- Back-to-back reads give back-to-back valid strobes, in issue order.
- `bist_res_valid_o` is low in cycle t+ReadLatency+2 once the last read is done. The generator relies on this low to leave its read phases.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- ReadLatency=1, 4 ways, PatternWidth=8: write all-zero to index 0..7, read 0..7 with a model returning zeros -> 8 consecutive valids, each 4'b1111; `err_cnt_o`=0.
- Read index 5 expecting 8'hFF, model returns way 2 = 8'hFB -> `bist_res_o`=4'b1011 at t+2; `err_cnt_o`=1; first_fail = {1, 5, 4'b0100}.
- Second failure at index 3, way 0 -> `err_cnt_o`=2; first_fail is still index 5, 4'b0100.
- ReadLatency=3, mixed write/read stream W R R W R -> exactly 3 valids, arriving 4 cycles after each read; no valid from the writes.
- CntWidth=4, 20 failing reads -> `err_cnt_o` = 4'hF with no wrap. `clear_i` coinciding with a fail -> counter 0, `first_fail_valid_o`=0, `bist_res_valid_o`=1.
- Assert `rst_i` for one cycle with 2 reads in flight -> no valid in the following cycles; all outputs at reset values.
